// File: rtl/fm_demod.sv
// fm_demod: FM discriminator placed directly after the complex channel FIR.
// Each sample is handled one at a time:
//   1. Pop one I/Q pair.
//   2. Form cur * conj(prev).
//   3. Take a quantized arctan approximation of the phase step.
//   4. Scale by GAIN and push one real sample to the audio FIFO.
// All arithmetic is signed fixed point in Q(BITS).
//
// Optional build macro: FM_DEMOD_ITER_DIV_EN
//   Defined   : the arctan quotient comes from a restoring radix-2 serial divider.
//               It works on magnitudes and fixes the sign afterwards.
//               DIV lasts DATA_WIDTH cycles, so pop->push = DATA_WIDTH+4 cycles.
//   Undefined : a single-cycle combinational divide, so pop->push = 5 cycles.
//   Both builds give bit-identical results.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   real_in      in   FIR real sample (FIFO dout, first-word fall-through)
//   imag_in      in   FIR imag sample (FIFO dout, first-word fall-through)
//   real_empty   in   real FIFO empty
//   imag_empty   in   imag FIFO empty
//   real_rd_en   out  pop real FIFO (asserted together with imag_rd_en)
//   imag_rd_en   out  pop imag FIFO
//   demod_out    out  demodulated sample, valid while demod_wr_en=1, else 0
//   demod_wr_en  out  push demod_out
//   demod_full   in   output FIFO full
module fm_demod #(
  parameter int DATA_WIDTH = 32,
  parameter int MULT_WIDTH = 64,
  parameter int BITS       = 10,
  parameter int GAIN       = 758,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] real_in,
  input  logic signed [DATA_WIDTH-1:0] imag_in,
  input  logic                         real_empty,
  input  logic                         imag_empty,
  output logic                         real_rd_en,
  output logic                         imag_rd_en,
  output logic signed [DATA_WIDTH-1:0] demod_out,
  output logic                         demod_wr_en,
  input  logic                         demod_full
);

  localparam logic signed [MULT_WIDTH-1:0] QUANT_M = MULT_WIDTH'(2 ** BITS);
  localparam logic signed [MULT_WIDTH-1:0] QUAD1_M = MULT_WIDTH'(QUAD1);
  localparam logic signed [MULT_WIDTH-1:0] QUAD3_M = MULT_WIDTH'(QUAD3);
  localparam logic signed [MULT_WIDTH-1:0] GAIN_M  = MULT_WIDTH'(GAIN);
  localparam logic signed [DATA_WIDTH-1:0] ONE_D   = DATA_WIDTH'(1);

  typedef enum logic [2:0] {S_READ, S_MULT, S_DIV, S_ANGLE, S_WRITE} state_t;

  state_t r_state, w_state_next;

  logic signed [DATA_WIDTH-1:0] r_cur_real, r_cur_imag, r_prev_real, r_prev_imag;
  logic signed [DATA_WIDTH-1:0] r_r, r_i, r_q, r_y, r_demod_out;
  logic                         r_wr_en;

  // Sign-extend a sample to product width.
  function automatic logic signed [MULT_WIDTH-1:0] sx(input logic signed [DATA_WIDTH-1:0] v);
    return $signed({{(MULT_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v});
  endfunction

  // Dequantize. Signed '/' truncates toward zero, which an arithmetic shift would not.
  function automatic logic signed [MULT_WIDTH-1:0] deq(input logic signed [MULT_WIDTH-1:0] v);
    return v / QUANT_M;
  endfunction

  logic w_pop;
  assign w_pop      = !rst && (r_state == S_READ) && !real_empty && !imag_empty;
  assign real_rd_en = w_pop;
  assign imag_rd_en = w_pop;

  // cur * conj(prev)
  logic signed [DATA_WIDTH-1:0] w_r, w_i;
  assign w_r = DATA_WIDTH'(deq(sx(r_prev_real) * sx(r_cur_real)) -
                          deq(-sx(r_prev_imag) * sx(r_cur_imag)));
  assign w_i = DATA_WIDTH'(deq(sx(r_prev_real) * sx(r_cur_imag)) +
                          deq(-sx(r_prev_imag) * sx(r_cur_real)));

  // Arctan ratio operands. The +1 keeps the denominator away from zero.
  logic signed [DATA_WIDTH-1:0] w_abs_y, w_diff, w_num, w_den, w_q;
  logic                         w_div_done;
  assign w_abs_y = ((r_i < 0) ? -r_i : r_i) + ONE_D;
  assign w_diff  = (r_r >= 0) ? (r_r - w_abs_y) : (r_r + w_abs_y);
  assign w_num   = w_diff <<< BITS;
  assign w_den   = (r_r >= 0) ? (r_r + w_abs_y) : (w_abs_y - r_r);

`ifdef FM_DEMOD_ITER_DIV_EN
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rem, r_quo;
  logic [DATA_WIDTH-1:0] w_num_mag, w_den_mag, w_rem_in, w_quo_in, w_rem_nx, w_quo_nx;
  logic [DATA_WIDTH:0]   w_rem_sh, w_sub;
  logic                  w_ge;

  // Unsigned view of |MIN| is still correct, so magnitudes never overflow.
  assign w_num_mag = w_num[DATA_WIDTH-1] ? DATA_WIDTH'(-w_num) : DATA_WIDTH'(w_num);
  assign w_den_mag = w_den[DATA_WIDTH-1] ? DATA_WIDTH'(-w_den) : DATA_WIDTH'(w_den);

  // The first iteration seeds the datapath directly from the operands,
  // so DIV lasts exactly DATA_WIDTH cycles.
  assign w_rem_in   = (r_cnt == '0) ? '0 : r_rem;
  assign w_quo_in   = (r_cnt == '0) ? w_num_mag : r_quo;
  assign w_rem_sh   = {w_rem_in, w_quo_in[DATA_WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, w_den_mag});
  assign w_sub      = w_rem_sh - {1'b0, w_den_mag};
  assign w_rem_nx   = w_ge ? w_sub[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
  assign w_quo_nx   = {w_quo_in[DATA_WIDTH-2:0], w_ge};
  assign w_q        = (w_num[DATA_WIDTH-1] ^ w_den[DATA_WIDTH-1]) ? -$signed(w_quo_nx)
                                                                  : $signed(w_quo_nx);
  assign w_div_done = (r_cnt == CNT_W'(DATA_WIDTH-1));
`else
  assign w_q        = w_num / w_den;
  assign w_div_done = 1'b1;
`endif

  // Arctan approximation and gain.
  logic signed [MULT_WIDTH-1:0] w_a_pos, w_a;
  logic signed [DATA_WIDTH-1:0] w_y;
  assign w_a_pos = ((r_r >= 0) ? QUAD1_M : QUAD3_M) - deq(QUAD1_M * sx(r_q));
  assign w_a     = (r_i < 0) ? -w_a_pos : w_a_pos;
  assign w_y     = DATA_WIDTH'(deq(GAIN_M * w_a));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_READ;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_READ:  if (w_pop) w_state_next = S_MULT;
      S_MULT:  w_state_next = S_DIV;
      S_DIV:   if (w_div_done) w_state_next = S_ANGLE;
      S_ANGLE: w_state_next = S_WRITE;
      S_WRITE: if (!demod_full) w_state_next = S_READ;
      default: w_state_next = S_READ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_real  <= '0;
      r_cur_imag  <= '0;
      r_prev_real <= '0;
      r_prev_imag <= '0;
      r_r         <= '0;
      r_i         <= '0;
      r_q         <= '0;
      r_y         <= '0;
      r_demod_out <= '0;
      r_wr_en     <= 1'b0;
`ifdef FM_DEMOD_ITER_DIV_EN
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
`endif
    end else begin
      r_wr_en     <= 1'b0;
      r_demod_out <= '0;
      case (r_state)
        S_READ: begin
          if (w_pop) begin
            r_cur_real <= real_in;
            r_cur_imag <= imag_in;
          end
        end
        S_MULT: begin
          r_r         <= w_r;
          r_i         <= w_i;
          r_prev_real <= r_cur_real;
          r_prev_imag <= r_cur_imag;
        end
        S_DIV: begin
`ifdef FM_DEMOD_ITER_DIV_EN
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= w_div_done ? '0 : r_cnt + 1'b1;
`endif
          if (w_div_done) r_q <= w_q;
        end
        S_ANGLE: r_y <= w_y;
        S_WRITE: begin
          if (!demod_full) begin
            r_wr_en     <= 1'b1;
            r_demod_out <= r_y;
          end
        end
        default: ;
      endcase
    end
  end

  assign demod_out   = r_demod_out;
  assign demod_wr_en = r_wr_en;

endmodule

// File: tb/tb_fm_demod.sv
// Testbench for fm_demod.
// Stimulus is a linear sequence of directed and random steps.
// Each DUT output is checked against an arithmetic model of the discriminator.
module tb_fm_demod;

`ifdef FM_DEMOD_ITER_DIV_EN
  localparam int LAT = 32 + 4;
`else
  localparam int LAT = 5;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] real_in, imag_in;
  logic               real_empty, imag_empty;
  logic               real_rd_en, imag_rd_en;
  logic signed [31:0] demod_out;
  logic               demod_wr_en;
  logic               demod_full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_pr   = 0;
  int m_pi   = 0;
  int txn_no = 0;

  fm_demod dut (
    .clk         (clk),
    .rst         (rst),
    .real_in     (real_in),
    .imag_in     (imag_in),
    .real_empty  (real_empty),
    .imag_empty  (imag_empty),
    .real_rd_en  (real_rd_en),
    .imag_rd_en  (imag_rd_en),
    .demod_out   (demod_out),
    .demod_wr_en (demod_wr_en),
    .demod_full  (demod_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Discriminator computed straight from its arithmetic definition.
  // 64-bit integer division truncates toward zero.
  function automatic int model(input int pr, input int pi, input int cr, input int ci);
    longint r, i, ay, num, den, q, a;
    r  = (longint'(pr) * cr) / 1024 - (-longint'(pi) * ci) / 1024;
    i  = (longint'(pr) * ci) / 1024 + (-longint'(pi) * cr) / 1024;
    ay = ((i < 0) ? -i : i) + 1;
    if (r >= 0) begin
      num = (r - ay) * 1024;
      den = r + ay;
    end else begin
      num = (r + ay) * 1024;
      den = ay - r;
    end
    q = num / den;
    a = ((r >= 0) ? 804 : 2412) - (804 * q) / 1024;
    if (i < 0) a = -a;
    return int'((758 * a) / 1024);
  endfunction

  // Offer a sample. Called at a negedge; returns at the negedge where the pop is visible.
  task automatic do_pop(input int re, input int im, output bit ok, output int t_pop);
    real_in = re; imag_in = im; real_empty = 1'b0; imag_empty = 1'b0;
    ok = 1'b0; t_pop = 0;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (real_rd_en || imag_rd_en) begin
        ok = 1'b1; t_pop = cyc;
        check("pop_pair", {30'b0, real_rd_en, imag_rd_en}, 3);
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("pop_timeout", 0, 1);
  endtask

  // Wait for the push while leaving input data available, counting illegal pops.
  task automatic wait_push(input int budget, output bit ok, output logic signed [31:0] y,
                           output int t_push, output int extra);
    ok = 1'b0; y = '0; t_push = 0; extra = 0;
    for (int k = 0; k < budget; k++) begin
      if (demod_wr_en === 1'b1) begin
        ok = 1'b1; y = demod_out; t_push = cyc;
        break;
      end
      if (real_rd_en || imag_rd_en) extra++;
      @(negedge clk);
    end
    real_empty = 1'b1; imag_empty = 1'b1;
    if (!ok) check("push_timeout", 0, 1);
    else begin
      @(negedge clk);
      check("wr_pulse_len", {31'b0, demod_wr_en}, 0);
    end
  endtask

  task automatic txn(input int re, input int im, output logic signed [31:0] y);
    int exp_y, t_pop, t_push, extra;
    bit ok;
    y = '0;
    exp_y = model(m_pr, m_pi, re, im);
    do_pop(re, im, ok, t_pop);
    if (ok) begin
      @(negedge clk);
      wait_push(300, ok, y, t_push, extra);
      m_pr = re; m_pi = im;
      if (ok) begin
        check("demod_out", y, exp_y);
        check("latency", t_push - t_pop, LAT);
        check("inflight_pops", extra, 0);
        txn_no++;
        $display("txn %0d: in=(%0d,%0d) out=%0d expect=%0d latency=%0d",
                 txn_no, re, im, y, exp_y, t_push - t_pop);
      end
    end
  endtask

  initial begin
    logic signed [31:0] y;
    int t_pop, t_push, extra, nwr, nrd;
    bit ok;

    // Reset with data available: no pops, no pushes, output zero.
    rst = 1'b1; demod_full = 1'b0;
    real_in = 32'sd7; imag_in = 32'sd9; real_empty = 1'b0; imag_empty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", {30'b0, real_rd_en, imag_rd_en}, 0);
    check("rst_wr_en", {31'b0, demod_wr_en}, 0);
    check("rst_out", demod_out, 0);
    real_empty = 1'b1; imag_empty = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Directed sequence from the reset state.
    txn(1024, 0, y);     check("dir1_const", y, 1190);
    txn(1024, 0, y);
    txn(0, 1024, y);     check("dir3_const", y, 1190);
    txn(0, -1024, y);

    // Random samples.
    for (int n = 0; n < 24; n++)
      txn(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192, y);

    // Output FIFO full: the result must wait, with no pops and no pushes.
    demod_full = 1'b1;
    begin
      int re, im, exp_y;
      re = int'($urandom_range(4000)) - 2000;
      im = int'($urandom_range(4000)) - 2000;
      exp_y = model(m_pr, m_pi, re, im);
      do_pop(re, im, ok, t_pop);
      m_pr = re; m_pi = im;
      nwr = 0; nrd = 0;
      @(negedge clk);
      for (int k = 0; k < 100; k++) begin
        if (demod_wr_en) nwr++;
        if (real_rd_en || imag_rd_en) nrd++;
        @(negedge clk);
      end
      check("stall_wr_en", nwr, 0);
      check("stall_pops", nrd, 0);
      demod_full = 1'b0;
      wait_push(50, ok, y, t_push, extra);
      check("stall_release_out", y, exp_y);
      check("stall_release_pops", extra, 0);
      $display("txn stall: in=(%0d,%0d) out=%0d expect=%0d", re, im, y, exp_y);
    end

    // One FIFO empty: neither FIFO may be popped.
    real_empty = 1'b0; imag_empty = 1'b1; nrd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (real_rd_en || imag_rd_en) nrd++;
    end
    check("real_only_pops", nrd, 0);
    real_empty = 1'b1; imag_empty = 1'b0; nrd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (real_rd_en || imag_rd_en) nrd++;
    end
    check("imag_only_pops", nrd, 0);
    imag_empty = 1'b1;
    @(negedge clk);

    // Reset while the sample is in DIV: no push, prev cleared.
    do_pop(5000, -3000, ok, t_pop);
    real_empty = 1'b1; imag_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_wr_en", {31'b0, demod_wr_en}, 0);
    check("midrst_out", demod_out, 0);
    rst = 1'b0;
    nwr = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (demod_wr_en) nwr++;
    end
    check("midrst_no_push", nwr, 0);
    m_pr = 0; m_pi = 0;
    txn(1024, 0, y);     check("post_rst_const", y, 1190);
    txn(-700, 2500, y);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
